// File: rtl/wowa_sar_sequencer.sv
// wowa_sar_sequencer: runs the shared 8-bit DAC and comparator through an
// 8-step successive-approximation search. A run is either a measurement,
// which is corrected by the stored offset, or an offset calibration.
// SETTLE_CYCLES must lie in 3..15. It includes the 2-flop synchronizer latency.
module wowa_sar_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       calib_req,
  input  logic       abort,
  input  logic       use_ext_thresh,
  input  logic       comp_out,
  output logic [7:0] dac_set,
  output logic       comp_nen,
  output logic       do_calibrate,
  output logic       thresh_sel,
  output logic       busy,
  output logic [7:0] result,
  output logic       result_ready,
  output logic       cal_valid
);

  typedef enum logic [1:0] {IDLE, ENABLE, TRIAL, DONE} state_t;
  typedef enum logic {MODE_MEAS, MODE_CAL} mode_t;

  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  state_t        state, state_n;
  mode_t         mode, mode_n;
  logic          comp_meta, comp_s;
  logic [7:0]    raw, raw_n;
  logic [2:0]    bit_idx, bit_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    cal_code, cal_code_n;
  logic [7:0]    result_n, dac_n;
  logic          ready_n, cal_valid_n, thresh_n;

  // Bring the asynchronous comparator output into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comp_meta <= 1'b0;
      comp_s    <= 1'b0;
    end else begin
      comp_meta <= comp_out;
      comp_s    <= comp_meta;
    end
  end

  // Next-state and datapath logic. An abort overrides everything a run would update.
  always_comb begin
    state_n     = state;
    mode_n      = mode;
    raw_n       = raw;
    bit_n       = bit_idx;
    cnt_n       = cnt;
    thresh_n    = thresh_sel;
    result_n    = result;
    ready_n     = 1'b0;
    cal_code_n  = cal_code;
    cal_valid_n = cal_valid;
    case (state)
      IDLE: begin
        if (calib_req) begin
          state_n  = ENABLE;
          mode_n   = MODE_CAL;
          thresh_n = use_ext_thresh;
        end else if (start) begin
          state_n  = ENABLE;
          mode_n   = MODE_MEAS;
          thresh_n = use_ext_thresh;
        end
      end
      ENABLE: begin
        raw_n   = 8'h00;
        bit_n   = 3'd7;
        cnt_n   = '0;
        state_n = TRIAL;
      end
      TRIAL: begin
        if (cnt == CNT_LAST) begin
          raw_n = raw | (8'(comp_s) << bit_idx);
          cnt_n = '0;
          if (bit_idx == 3'd0) begin
            state_n = DONE;
            if (mode == MODE_CAL) begin
              cal_code_n  = raw_n;
              cal_valid_n = 1'b1;
            end else begin
              result_n = (raw_n >= cal_code) ? (raw_n - cal_code) : 8'h00;
              ready_n  = 1'b1;
            end
          end else begin
            bit_n = bit_idx - 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_n     = IDLE;
      raw_n       = raw;
      bit_n       = bit_idx;
      cnt_n       = cnt;
      result_n    = result;
      ready_n     = 1'b0;
      cal_code_n  = cal_code;
      cal_valid_n = cal_valid;
    end
    dac_n = (state_n == TRIAL) ? (raw_n | (8'd1 << bit_n)) : raw_n;
  end

  // Register state, datapath and all pins driven to the analog macro
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mode         <= MODE_MEAS;
      raw          <= 8'h00;
      bit_idx      <= 3'd7;
      cnt          <= '0;
      cal_code     <= 8'h00;
      cal_valid    <= 1'b0;
      result       <= 8'h00;
      result_ready <= 1'b0;
      thresh_sel   <= 1'b0;
      dac_set      <= 8'h00;
      comp_nen     <= 1'b1;
      do_calibrate <= 1'b0;
    end else begin
      state        <= state_n;
      mode         <= mode_n;
      raw          <= raw_n;
      bit_idx      <= bit_n;
      cnt          <= cnt_n;
      cal_code     <= cal_code_n;
      cal_valid    <= cal_valid_n;
      result       <= result_n;
      result_ready <= ready_n;
      thresh_sel   <= thresh_n;
      dac_set      <= dac_n;
      comp_nen     <= (state_n == IDLE);
      do_calibrate <= (state_n != IDLE) && (mode_n == MODE_CAL);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_wowa_sar_sequencer.sv
// tb_wowa_sar_sequencer: directed runs against a comparator model
// comp_out = (target >= dac_set). Expected results are queued when a
// measurement is issued and popped by a monitor on every result_ready.
module tb_wowa_sar_sequencer;

  localparam int S = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       calib_req;
  logic       abort;
  logic       use_ext_thresh;
  logic       comp_out;
  logic [7:0] dac_set;
  logic       comp_nen;
  logic       do_calibrate;
  logic       thresh_sel;
  logic       busy;
  logic [7:0] result;
  logic       result_ready;
  logic       cal_valid;

  logic [7:0] target;
  logic       glitch;

  int         pass_cnt;
  int         check_cnt;
  int         cyc;
  int         req_cyc;
  int         ready_cyc;
  int         busy_k;
  int         last_busy_len;
  int         dcal_cnt;
  int         thr_cnt;
  logic [7:0] exp_q[$];
  logic [7:0] trial_q[$];
  logic [7:0] exp_v;

  wowa_sar_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .calib_req      (calib_req),
    .abort          (abort),
    .use_ext_thresh (use_ext_thresh),
    .comp_out       (comp_out),
    .dac_set        (dac_set),
    .comp_nen       (comp_nen),
    .do_calibrate   (do_calibrate),
    .thresh_sel     (thresh_sel),
    .busy           (busy),
    .result         (result),
    .result_ready   (result_ready),
    .cal_valid      (cal_valid)
  );

  // Ideal comparator with an optional injected glitch
  assign comp_out = (target >= dac_set) ^ glitch;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency measurement
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  // Monitor: scoreboard pops on result_ready and records per-run statistics
  always @(negedge clk) begin
    if (result_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_ready", 1, 0);
      end else begin
        exp_v = exp_q.pop_front();
        checkOutput("result", {24'd0, result}, {24'd0, exp_v});
        ready_cyc = cyc;
      end
    end
    if (busy === 1'b1) begin
      if (busy_k == 0) begin
        trial_q.delete();
        dcal_cnt = 0;
        thr_cnt  = 0;
      end
      busy_k++;
      if (busy_k >= 2 && busy_k <= 2 + 7 * S && ((busy_k - 2) % S) == 0) trial_q.push_back(dac_set);
      dcal_cnt += int'(do_calibrate);
      thr_cnt  += int'(thresh_sel);
    end else if (busy_k != 0) begin
      last_busy_len = busy_k;
      busy_k = 0;
    end
  end

  task automatic applyStimulus(input logic s, input logic c, input logic ext, input logic ab);
    @(negedge clk); #1;
    start = s; calib_req = c; use_ext_thresh = ext; abort = ab;
    req_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0; calib_req = 1'b0; abort = 1'b0;
  endtask

  task automatic waitRunEnd(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput({name, "_ends"}, 32'(busy), 0);
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    logic [7:0] exp_trials [8];
    exp_trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    pass_cnt = 0; check_cnt = 0; busy_k = 0; last_busy_len = 0;
    dcal_cnt = 0; thr_cnt = 0; ready_cyc = 0; req_cyc = 0;
    rst_n = 1'b0; start = 1'b0; calib_req = 1'b0; abort = 1'b0;
    use_ext_thresh = 1'b0; target = 8'h00; glitch = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_dac", {24'd0, dac_set}, 0);
    checkOutput("rst_comp_nen", 32'(comp_nen), 1);
    checkOutput("rst_do_cal", 32'(do_calibrate), 0);
    checkOutput("rst_thresh", 32'(thresh_sel), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_result", {24'd0, result}, 0);
    checkOutput("rst_ready", 32'(result_ready), 0);
    checkOutput("rst_cal_valid", 32'(cal_valid), 0);
    rst_n = 1'b1;

    // Uncorrected measurement of 0xA5
    target = 8'hA5;
    exp_q.push_back(8'hA5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("a5_comp_en", 32'(comp_nen), 0);
    waitRunEnd("a5");
    checkOutput("a5_busy_len", 32'(last_busy_len), 34);
    checkOutput("a5_latency", 32'(ready_cyc - req_cyc), 34);
    checkOutput("a5_trial_count", 32'(trial_q.size()), 8);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("a5_trial%0d", i), {24'd0, trial_q[i]}, {24'd0, exp_trials[i]});
    checkOutput("a5_dac_hold", {24'd0, dac_set}, 32'hA5);
    checkOutput("a5_comp_off", 32'(comp_nen), 1);
    checkOutput("a5_no_cal", 32'(dcal_cnt), 0);

    // Calibration on 0x03, then corrected measurement of 0x50
    target = 8'h03;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitRunEnd("cal3");
    checkOutput("cal3_valid", 32'(cal_valid), 1);
    checkOutput("cal3_result_held", {24'd0, result}, 32'hA5);
    checkOutput("cal3_do_cal_len", 32'(dcal_cnt), 34);
    checkOutput("cal3_do_cal_off", 32'(do_calibrate), 0);
    target = 8'h50;
    exp_q.push_back(8'h4D);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitRunEnd("m50");
    checkOutput("m50_no_cal", 32'(dcal_cnt), 0);

    // Saturation below the offset
    target = 8'h01;
    exp_q.push_back(8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitRunEnd("m01");

    // Simultaneous requests: calibration first, held start follows after one IDLE cycle
    @(negedge clk); #1;
    target = 8'h05; start = 1'b1; calib_req = 1'b1;
    @(negedge clk); #1;
    checkOutput("both_cal_first", 32'(do_calibrate), 1);
    calib_req = 1'b0;
    waitRunEnd("both_cal");
    checkOutput("both_cal_valid", 32'(cal_valid), 1);
    target = 8'h90;
    exp_q.push_back(8'h8B);
    @(negedge clk); #1;
    checkOutput("both_meas_started", 32'(busy), 1);
    checkOutput("both_meas_not_cal", 32'(do_calibrate), 0);
    start = 1'b0;
    waitRunEnd("both_meas");

    // Abort during the bit-4 trial
    target = 8'h33;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (14) begin
      @(negedge clk); #1;
    end
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_idle", 32'(busy), 0);
    checkOutput("abort_comp_off", 32'(comp_nen), 1);
    checkOutput("abort_result_held", {24'd0, result}, 32'h8B);

    // External threshold with abort in IDLE, mid-run toggle, and comparator glitch
    target = 8'h5A;
    exp_q.push_back(8'h55);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk); #1;
    glitch = 1'b1;
    use_ext_thresh = 1'b0;
    @(negedge clk); #1;
    glitch = 1'b0;
    waitRunEnd("ext");
    checkOutput("ext_thresh_len", 32'(thr_cnt), 34);
    checkOutput("ext_busy_len", 32'(last_busy_len), 34);
    checkOutput("glitch_bit6_trial", {24'd0, trial_q[1]}, 32'h40);

    // Asynchronous reset mid-run
    target = 8'h77;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (9) begin
      @(negedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 0);
    checkOutput("arst_comp_nen", 32'(comp_nen), 1);
    checkOutput("arst_dac", {24'd0, dac_set}, 0);
    checkOutput("arst_result", {24'd0, result}, 0);
    checkOutput("arst_cal_valid", 32'(cal_valid), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // After reset the offset is cleared again
    target = 8'h42;
    exp_q.push_back(8'h42);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitRunEnd("post_rst");
    @(negedge clk); #1;
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/wowa_sar_sequencer.md
# wowa_sar_sequencer

Sequences the shared 8-bit DAC and analog comparator through an 8-step successive-approximation search. Converts user requests into either a measurement or an offset-calibration run, and drives the analog macro's DAC bits, USEEXT, CAL and EN_N pins. It sits between the pad-level control inputs and the analog macro, and returns an offset-corrected 8-bit result with a one-cycle ready strobe.

## Interface
- SETTLE_CYCLES, 4: cycles each trial DAC code is held before the comparator is sampled. Legal range is 3..15; the 2-flop synchronizer latency is included.
- clk  in  1  design clock (10 MHz nominal)
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  measurement request; level, sampled only in IDLE
- calib_req  in  1  calibration request; level, sampled only in IDLE
- abort  in  1  synchronous abort of any run in progress
- use_ext_thresh  in  1  threshold-source select, latched at run start
- comp_out  in  1  raw comparator output; asynchronous to clk, 1 = input above DAC level
- dac_set  out  8  trial code driven to the DAC
- comp_nen  out  1  comparator enable, active low
- do_calibrate  out  1  CAL pin; high for the whole calibration run
- thresh_sel  out  1  USEEXT pin
- busy  out  1  high whenever the state is not IDLE
- result  out  8  last corrected measurement; held until the next measurement completes
- result_ready  out  1  one-cycle pulse when result updates
- cal_valid  out  1  high once a calibration has completed since reset

## Operation
- comp_out passes through a 2-flop synchronizer to produce comp_s. No other logic samples comp_out directly.
- States: IDLE, ENABLE, TRIAL, DONE.
- IDLE:
  - If calib_req=1, go to ENABLE with mode=CAL. calib_req has priority over start.
  - Else if start=1, go to ENABLE with mode=MEAS.
  - Latch use_ext_thresh into thresh_sel. Set do_calibrate = (mode==CAL).
- ENABLE (1 cycle):
  - Drive comp_nen=0.
  - Clear the working register raw to 0.
  - Set bit index i=7.
  - Go to TRIAL.
- TRIAL:
  - dac_set = raw | (1<<i).
  - A counter runs 0..SETTLE_CYCLES-1.
  - On the final count, sample comp_s:
    - comp_s=1: keep bit i in raw.
    - comp_s=0: leave bit i clear.
  - If i=0, go to DONE. Otherwise decrement i and re-enter TRIAL with the counter reset.
- DONE (1 cycle):
  - MEAS: result = raw - cal_code when raw >= cal_code, else 0 (unsigned saturate, 8 bits). Pulse result_ready=1.
  - CAL: cal_code = raw and cal_valid=1. result and result_ready are untouched.
  - Return to IDLE. There comp_nen=1, do_calibrate=0, and dac_set holds the final raw value.
- cal_code is an internal 8-bit register with reset value 0. Before any calibration, measurements are uncorrected.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, with comp_nen=1 and do_calibrate=0.
  - No result_ready is issued, and result, cal_code and cal_valid are unchanged.
  - abort in IDLE has no effect and blocks nothing.
- start and calib_req are ignored while busy=1. A request still held high when the state returns to IDLE launches a new run on the next edge.
- Reset values: dac_set=0x00, comp_nen=1, do_calibrate=0, thresh_sel=0, busy=0, result=0x00, result_ready=0, cal_valid=0, cal_code=0, state=IDLE. Synchronizer flops reset to 0.
- Asserting rst_n low mid-run forces all reset values immediately (asynchronously), including cal_valid and cal_code.

## Timing
- Let S = SETTLE_CYCLES, and let edge 0 be the edge that samples a request in IDLE.
- Edge 1: state is ENABLE, comp_nen=0 and busy=1.
- Edges 2 .. 1+8S: TRIAL states. Bit i is presented from edge 2+(7-i)·S and is sampled on edge 1+(8-i)·S.
- Edge 2+8S: DONE, with result and result_ready valid in that cycle.
- Edge 3+8S: IDLE.
- For S=4: result_ready is high in the cycle after edge 34 and busy is high for 34 cycles. Total latency, request to ready, is 34 cycles.
- comp_out must be stable at least S-2 cycles after a dac_set change. The analog settle budget is (S-2)×100 ns at 10 MHz.
- Back-to-back runs: at least one IDLE cycle separates runs.

## Test plan
- Reset, then start=1 for 1 cycle with the comparator model giving comp_out = (0xA5 >= dac_set), S=4 → trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5 → result=0xA5, result_ready pulse after exactly 34 cycles, busy=1 for 34 cycles.
- calib_req with model target 0x03, then start with target 0x50 → cal_valid=1, no ready pulse on the cal run, do_calibrate=1 only during the cal run, result=0x4D.
- With cal_code=0x03, measure target 0x01 → result=0x00 (saturation).
- Assert start and calib_req together → calibration runs first; with start still held, a measurement follows one IDLE cycle later.
- Assert abort during the bit-4 trial → IDLE next cycle, comp_nen=1, no result_ready, previous result held. Assert rst_n low mid-run → all outputs at reset values immediately, cal_valid=0.
- use_ext_thresh=1 at start, toggled mid-run → thresh_sel stays 1 for the whole run. Comp_out glitch during the first S-2 cycles of a trial → no effect on the sampled bit.
